// File: rtl/floating_point_blocking_seq.sv
// ============================================================================
//  Module   : floating_point_blocking_seq
//  Purpose  : ROM-patterned AXI-Stream traffic sequencer feeding an FP core's
//             a/b/c/operation channels and draining its result channel.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module floating_point_blocking_seq #(
    parameter int N_TXN       = 16,
    parameter int PATTERN_LEN = 20,
    parameter int TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  rom_addr,
    input  logic [4:0]  rom_dout,
    output logic        s_axis_a_tvalid,
    input  logic        s_axis_a_tready,
    output logic [31:0] s_axis_a_tdata,
    output logic        s_axis_b_tvalid,
    input  logic        s_axis_b_tready,
    output logic [31:0] s_axis_b_tdata,
    output logic        s_axis_c_tvalid,
    input  logic        s_axis_c_tready,
    output logic [31:0] s_axis_c_tdata,
    output logic        s_axis_operation_tvalid,
    input  logic        s_axis_operation_tready,
    output logic [7:0]  s_axis_operation_tdata,
    input  logic        m_axis_result_tvalid,
    output logic        m_axis_result_tready,
    output logic [7:0]  result_cnt,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_prime = 2'd1;
    localparam logic [1:0] c_run   = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam int         TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [7:0] c_n_txn   = 8'(N_TXN);
    localparam logic [4:0] c_last    = 5'(PATTERN_LEN - 1);
    localparam logic [TO_W-1:0] c_timeout = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] c_to_one  = TO_W'(1);

    logic [1:0]       r_state;
    logic [4:0]       r_rom_addr;
    logic [3:0]       r_tvalid;       // [3]=a [2]=b [1]=c [0]=operation
    logic [3:0][7:0]  r_cnt;
    logic [7:0]       r_result_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_done;
    logic             r_error;

    logic [3:0]       w_tready;
    logic [3:0]       w_hs;
    logic [3:0]       w_tv_nxt;
    logic [3:0]       w_chan_full;
    logic [3:0][7:0]  w_cnt_nxt;
    logic             w_res_tready;
    logic             w_res_hs;
    logic [7:0]       w_res_nxt;
    logic             w_any_hs;
    logic             w_complete;
    logic             w_timeout;
    logic [4:0]       w_addr_nxt;

    assign w_tready = {s_axis_a_tready, s_axis_b_tready,
                       s_axis_c_tready, s_axis_operation_tready};

    // Channel i is driven by pattern bit i+1; bit 0 belongs to the result channel.
    for (genvar i = 0; i < 4; i++) begin : g_chan
        assign w_hs[i]        = r_tvalid[i] & w_tready[i];
        assign w_cnt_nxt[i]   = r_cnt[i] + {7'd0, w_hs[i]};
        assign w_chan_full[i] = (w_cnt_nxt[i] == c_n_txn);
        // A stalled offer must persist regardless of what the pattern says.
        assign w_tv_nxt[i]    = (r_tvalid[i] & ~w_tready[i]) |
                                (rom_dout[i+1] & (w_cnt_nxt[i] < c_n_txn));
    end

    assign w_res_tready = (r_state == c_run) & rom_dout[0] & (r_result_cnt < c_n_txn);
    assign w_res_hs     = m_axis_result_tvalid & w_res_tready;
    assign w_res_nxt    = r_result_cnt + {7'd0, w_res_hs};
    assign w_any_hs     = (|w_hs) | w_res_hs;
    assign w_complete   = (&w_chan_full) & (w_res_nxt == c_n_txn);
    assign w_timeout    = ~w_any_hs & ((r_to_cnt + c_to_one) == c_timeout);
    assign w_addr_nxt   = (r_rom_addr == c_last) ? 5'd0 : r_rom_addr + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_rom_addr   <= 5'd0;
            r_tvalid     <= 4'd0;
            r_cnt        <= '0;
            r_result_cnt <= 8'd0;
            r_to_cnt     <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                c_prime: begin
                    r_state    <= c_run;
                    r_rom_addr <= w_addr_nxt;
                end
                c_run: begin
                    r_rom_addr   <= w_addr_nxt;
                    r_cnt        <= w_cnt_nxt;
                    r_result_cnt <= w_res_nxt;
                    r_to_cnt     <= w_any_hs ? '0 : r_to_cnt + c_to_one;
                    if (w_complete || w_timeout) begin
                        r_state  <= c_done;
                        r_tvalid <= 4'd0;
                        r_done   <= 1'b1;
                        r_error  <= ~w_complete;
                    end else begin
                        r_tvalid <= w_tv_nxt;
                    end
                end
                default: begin
                    if (start) begin
                        r_state      <= c_prime;
                        r_rom_addr   <= 5'd0;
                        r_tvalid     <= 4'd0;
                        r_cnt        <= '0;
                        r_result_cnt <= 8'd0;
                        r_to_cnt     <= '0;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign rom_addr                = r_rom_addr;
    assign s_axis_a_tvalid         = r_tvalid[3];
    assign s_axis_b_tvalid         = r_tvalid[2];
    assign s_axis_c_tvalid         = r_tvalid[1];
    assign s_axis_operation_tvalid = r_tvalid[0];
    assign s_axis_a_tdata          = {24'd0, r_cnt[3]};
    assign s_axis_b_tdata          = {24'd0, r_cnt[2]};
    assign s_axis_c_tdata          = {24'd0, r_cnt[1]};
    assign s_axis_operation_tdata  = r_cnt[0];
    assign m_axis_result_tready    = w_res_tready;
    assign result_cnt              = r_result_cnt;
    assign busy                    = (r_state == c_prime) | (r_state == c_run);
    assign done                    = r_done;
    assign error                   = r_error;

endmodule

`default_nettype wire

// File: tb/tb_floating_point_blocking_seq.sv
// ============================================================================
//  Module   : tb_floating_point_blocking_seq
//  Purpose  : Scoreboard bench for floating_point_blocking_seq (default and
//             N_TXN=1 instances).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_floating_point_blocking_seq;

    localparam int TIMEOUT = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [4:0] pat_mem [0:31];

    // Instance 0: defaults
    logic        start = 1'b0;
    logic [4:0]  rom_addr, rom_dout;
    logic        a_tv, b_tv, c_tv, op_tv;
    logic        a_tr = 1'b0, b_tr = 1'b0, c_tr = 1'b0, op_tr = 1'b0;
    logic [31:0] a_td, b_td, c_td;
    logic [7:0]  op_td, result_cnt;
    logic        res_tv = 1'b0, res_tr, busy, done, error;

    // Instance 1: N_TXN = 1
    logic        start1 = 1'b0;
    logic [4:0]  rom_addr1, rom_dout1;
    logic        a_tv1, b_tv1, c_tv1, op_tv1;
    logic [31:0] a_td1, b_td1, c_td1;
    logic [7:0]  op_td1, result_cnt1;
    logic        res_tv1 = 1'b0, res_tr1, busy1, done1, error1;

    floating_point_blocking_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_dout(rom_dout),
        .s_axis_a_tvalid(a_tv), .s_axis_a_tready(a_tr), .s_axis_a_tdata(a_td),
        .s_axis_b_tvalid(b_tv), .s_axis_b_tready(b_tr), .s_axis_b_tdata(b_td),
        .s_axis_c_tvalid(c_tv), .s_axis_c_tready(c_tr), .s_axis_c_tdata(c_td),
        .s_axis_operation_tvalid(op_tv), .s_axis_operation_tready(op_tr),
        .s_axis_operation_tdata(op_td),
        .m_axis_result_tvalid(res_tv), .m_axis_result_tready(res_tr),
        .result_cnt(result_cnt), .busy(busy), .done(done), .error(error)
    );

    floating_point_blocking_seq #(.N_TXN(1), .PATTERN_LEN(20), .TIMEOUT(TIMEOUT)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .rom_addr(rom_addr1), .rom_dout(rom_dout1),
        .s_axis_a_tvalid(a_tv1), .s_axis_a_tready(1'b1), .s_axis_a_tdata(a_td1),
        .s_axis_b_tvalid(b_tv1), .s_axis_b_tready(1'b1), .s_axis_b_tdata(b_td1),
        .s_axis_c_tvalid(c_tv1), .s_axis_c_tready(1'b1), .s_axis_c_tdata(c_td1),
        .s_axis_operation_tvalid(op_tv1), .s_axis_operation_tready(1'b1),
        .s_axis_operation_tdata(op_td1),
        .m_axis_result_tvalid(res_tv1), .m_axis_result_tready(res_tr1),
        .result_cnt(result_cnt1), .busy(busy1), .done(done1), .error(error1)
    );

    initial begin
        for (int i = 0; i < 32; i++) pat_mem[i] = 5'b00000;
        pat_mem[0]  = 5'b11111; pat_mem[1]  = 5'b10101; pat_mem[2]  = 5'b01011;
        pat_mem[3]  = 5'b11110; pat_mem[4]  = 5'b00111; pat_mem[5]  = 5'b11001;
        pat_mem[6]  = 5'b01101; pat_mem[7]  = 5'b10011; pat_mem[8]  = 5'b11111;
        pat_mem[9]  = 5'b00000; pat_mem[10] = 5'b10110; pat_mem[11] = 5'b01111;
        pat_mem[12] = 5'b11011; pat_mem[13] = 5'b00101; pat_mem[14] = 5'b11100;
        pat_mem[15] = 5'b01010; pat_mem[16] = 5'b10001; pat_mem[17] = 5'b11111;
        pat_mem[18] = 5'b00110; pat_mem[19] = 5'b11101;
    end

    // Synchronous ROMs: one cycle read latency
    always @(posedge clk) begin
        rom_dout  <= pat_mem[rom_addr];
        rom_dout1 <= pat_mem[rom_addr1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard queues: expected tdata (or pre-beat result_cnt) per accepted beat
    int q_a[$], q_b[$], q_c[$], q_op[$], q_res[$];

    task automatic push_run(input int n);
        for (int i = 0; i < n; i++) begin
            q_a.push_back(i); q_b.push_back(i); q_c.push_back(i);
            q_op.push_back(i); q_res.push_back(i);
        end
    endtask

    task automatic chk_queues_empty();
        chk("q_a_left",   q_a.size(),   0);
        chk("q_b_left",   q_b.size(),   0);
        chk("q_c_left",   q_c.size(),   0);
        chk("q_op_left",  q_op.size(),  0);
        chk("q_res_left", q_res.size(), 0);
    endtask

    // Monitor: handshakes seen mid-cycle complete at the next rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_tv && a_tr) begin
                if (q_a.size() == 0) chk("a_unexpected", 1, 0);
                else chk("a_tdata", a_td, q_a.pop_front());
            end
            if (b_tv && b_tr) begin
                if (q_b.size() == 0) chk("b_unexpected", 1, 0);
                else chk("b_tdata", b_td, q_b.pop_front());
            end
            if (c_tv && c_tr) begin
                if (q_c.size() == 0) chk("c_unexpected", 1, 0);
                else chk("c_tdata", c_td, q_c.pop_front());
            end
            if (op_tv && op_tr) begin
                if (q_op.size() == 0) chk("op_unexpected", 1, 0);
                else chk("op_tdata", {24'd0, op_td}, q_op.pop_front());
            end
            if (res_tv && res_tr) begin
                if (q_res.size() == 0) chk("res_unexpected", 1, 0);
                else chk("result_cnt_beat", {24'd0, result_cnt}, q_res.pop_front());
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        chk("done_reached", done, 1);
    endtask

    task automatic set_readies(input logic v);
        a_tr = v; b_tr = v; c_tr = v; op_tr = v; res_tv = v;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tvalid", {a_tv, b_tv, c_tv, op_tv}, 4'b0000);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_res_tready", res_tr, 0);
        rst_n = 1'b1;
        tick();

        // Full run, all channels always ready
        set_readies(1'b1);
        push_run(16);
        pulse_start();
        chk("prime_busy", busy, 1);
        chk("prime_rom_addr", rom_addr, 0);
        chk("prime_tvalid", {a_tv, b_tv, c_tv, op_tv}, 4'b0000);
        tick();
        chk("run1_tvalid", {a_tv, b_tv, c_tv, op_tv}, 4'b0000);
        chk("run1_rom_addr", rom_addr, 1);
        chk("run1_res_tready", res_tr, 1);
        tick();
        chk("run2_tvalid", {a_tv, b_tv, c_tv, op_tv}, 4'b1111);
        tick();
        chk("run3_tvalid", {a_tv, b_tv, c_tv, op_tv}, 4'b1010);
        wait_done(400);
        chk("t1_error", error, 0);
        chk("t1_busy", busy, 0);
        chk("t1_a_cnt", a_td, 16);
        chk("t1_b_cnt", b_td, 16);
        chk("t1_c_cnt", c_td, 16);
        chk("t1_op_cnt", {24'd0, op_td}, 16);
        chk("t1_result_cnt", {24'd0, result_cnt}, 16);
        chk("t1_tvalid_idle", {a_tv, b_tv, c_tv, op_tv, res_tr}, 5'b00000);
        chk_queues_empty();

        // Stalled a-channel keeps its offer and data stable
        a_tr = 1'b0;
        push_run(16);
        pulse_start();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("stall_a_tvalid", a_tv, 1);
            chk("stall_a_tdata", a_td, 0);
            tick();
        end
        a_tr = 1'b1;
        wait_done(400);
        chk("t2_error", error, 0);
        chk("t2_a_cnt", a_td, 16);
        chk_queues_empty();

        // Nothing ever accepted: timeout exactly TIMEOUT cycles after RUN entry
        set_readies(1'b0);
        pulse_start();
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("to_not_yet", done, 0);
        tick();
        chk("to_done", done, 1);
        chk("to_error", error, 1);
        chk("to_tvalid", {a_tv, b_tv, c_tv, op_tv, res_tr}, 5'b00000);

        // Asynchronous reset mid-run with a stalled offer
        pulse_start();
        tick();
        tick();
        chk("pre_rst_a_tvalid", a_tv, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tvalid", {a_tv, b_tv, c_tv, op_tv, res_tr}, 5'b00000);
        chk("arst_flags", {busy, done, error}, 3'b000);
        chk("arst_rom_addr", rom_addr, 0);
        chk("arst_a_tdata", a_td, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", {busy, a_tv, b_tv, c_tv, op_tv}, 5'b00000);
        set_readies(1'b1);
        push_run(16);
        pulse_start();
        wait_done(400);
        chk("t4_error", error, 0);
        chk("t4_result_cnt", {24'd0, result_cnt}, 16);
        chk_queues_empty();

        // N_TXN=1 instance: wrap while waiting for results, ignored/accepted starts
        res_tv1 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 40 && rom_addr1 != 5'd19; i++) tick();
        chk("n1_addr19", rom_addr1, 19);
        tick();
        chk("n1_wrap", rom_addr1, 0);
        chk("n1_busy_wrap", busy1, 1);
        for (int i = 0; i < 25 && rom_addr1 != 5'd5; i++) tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1_start_ignored", rom_addr1, 6);
        chk("n1_busy_run", busy1, 1);
        res_tv1 = 1'b1;
        for (int i = 0; i < 60 && !done1; i++) tick();
        chk("n1_done", done1, 1);
        chk("n1_error", error1, 0);
        chk("n1_result_cnt", {24'd0, result_cnt1}, 1);
        chk("n1_cnts", {a_td1[7:0], b_td1[7:0], c_td1[7:0], op_td1}, 32'h01010101);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1_restart", {busy1, done1, rom_addr1}, {2'b10, 5'd0});
        for (int i = 0; i < 60 && !done1; i++) tick();
        chk("n1_done2", {done1, error1}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/floating_point_blocking_seq.md
FLOATING_POINT_BLOCKING_SEQ -- requirements
Module: floating_point_blocking_seq

Interface
REQ-001 Parameters: N_TXN, default 16, transfers per channel (1..255); PATTERN_LEN, default 20, pattern ROM depth (1..32); TIMEOUT, default 1024, idle cycles before abort.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; begins a run.
REQ-005 rom_addr  output  5  pattern ROM read address.
REQ-006 rom_dout  input  5  ROM data, valid one cycle after rom_addr; bit4=a, bit3=b, bit2=c, bit1=operation tvalid enables, bit0=result tready enable.
REQ-007 s_axis_{a,b,c,operation}_tvalid  output  1 each  operand/op offers to FP core.
REQ-008 s_axis_{a,b,c,operation}_tready  input  1 each  FP core accepts.
REQ-009 s_axis_{a,b,c}_tdata  output  32 each  channel accepted-count zero-extended; s_axis_operation_tdata output 8, same rule.
REQ-010 m_axis_result_tvalid  input  1; m_axis_result_tready  output  1.
REQ-011 result_cnt  output  8  accepted result beats; busy, done, error  output  1 each  status.

Function
REQ-012 States IDLE, PRIME, RUN, DONE; IDLE->PRIME on start; PRIME->RUN after exactly one cycle; RUN->DONE on completion or timeout; DONE->PRIME on start.
REQ-013 start in PRIME or RUN shall be ignored.
REQ-014 Entering PRIME shall clear all channel counts, result_cnt, timeout counter, done, error; rom_addr=0.
REQ-015 rom_addr shall increment every cycle in PRIME and RUN, wrapping PATTERN_LEN-1 -> 0; held in IDLE/DONE.
REQ-016 In RUN, pattern = rom_dout of the current cycle (ROM latency absorbed by PRIME).
REQ-017 Handshake on channel X when tvalid_X && tready_X on a clock edge; channel count increments that edge.
REQ-018 tvalid_X asserted without handshake shall remain 1 next cycle regardless of pattern (AXI stability).
REQ-019 Otherwise next tvalid_X = pattern bit X AND (count_X after this edge < N_TXN).
REQ-020 tdata_X shall equal count_X and stay stable while tvalid_X is high.
REQ-021 m_axis_result_tready = pattern bit0 AND result_cnt < N_TXN, only in RUN; 0 elsewhere; may drop without handshake.
REQ-022 Result beat when m_axis_result_tvalid && m_axis_result_tready; result_cnt increments.
REQ-023 Completion: all four channel counts == N_TXN and result_cnt == N_TXN -> DONE, done=1, error=0.
REQ-024 Timeout counter increments each RUN cycle with no handshake on any of the five channels, clears on any handshake; reaching TIMEOUT -> DONE, done=1, error=1.
REQ-025 In DONE all tvalid and result_tready shall be 0; counts held for readout.
REQ-026 busy=1 in PRIME and RUN, else 0.
REQ-027 Simultaneous handshakes on several channels in one cycle shall all be counted.

Reset
REQ-028 rst_n low, any state incl. mid-run: state=IDLE, rom_addr=0, all tvalid=0, result_tready=0, all counts 0, tdata 0, busy=done=error=0, immediately (asynchronous).
REQ-029 Release of rst_n synchronous to clk; no transfer offered before the next start.

Verification
REQ-030 ROM model with standard 20-entry pattern, all tready=1, result tvalid=1, start -> after 1 PRIME cycle, tvalid follows pattern; done=1, error=0, all counts=16, result_cnt=16.
REQ-031 a_tready held 0 for 10 cycles while a_tvalid=1 -> a_tvalid and a_tdata stable across all 10 cycles despite pattern bit4=0.
REQ-032 All tready=0 and result tvalid=0 after start -> done=1, error=1 exactly TIMEOUT cycles after RUN entry; all tvalid=0.
REQ-033 rst_n pulsed low mid-RUN with a_tvalid=1 -> outputs zero same cycle; start after release -> fresh run, counts from 0.
REQ-034 N_TXN=1, PATTERN_LEN=20 -> each channel single transfer, rom_addr wraps 19->0 while waiting on results; start during RUN ignored; start in DONE restarts.
